// File: rtl/ex_div_pkg.sv
// Shared types, constants and small arithmetic helpers for the execute-stage divider.
package ex_div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Two's complement negation of a 32-bit word.
    function automatic logic [RegBus-1:0] negate(input logic [RegBus-1:0] v);
        return (~v) + 32'd1;
    endfunction

    // Magnitude of an operand; raw value for unsigned division.
    function automatic logic [RegBus-1:0] magnitude(input logic is_signed, input logic [RegBus-1:0] v);
        return (is_signed && v[RegBus-1]) ? negate(v) : v;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; one division in flight,
// annullable while iterating, result held until the requester drops start_i.
module ex_div
    import ex_div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e              state_r,    state_s;
    logic [64:0]             dividend_r, dividend_s;
    logic [RegBus-1:0]       divisor_r,  divisor_s;
    logic [5:0]              cnt_r,      cnt_s;
    logic                    sign1_r,    sign1_s;
    logic                    sign2_r,    sign2_s;
    logic [DoubleRegBus-1:0] result_r,   result_s;
    logic                    ready_r,    ready_s;

    logic [32:0]             diff_s;
    logic [RegBus-1:0]       quot_fix_s;
    logic [RegBus-1:0]       rem_fix_s;

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= DivFree;
            dividend_r <= 65'd0;
            divisor_r  <= ZeroWord;
            cnt_r      <= 6'd0;
            sign1_r    <= 1'b0;
            sign2_r    <= 1'b0;
            result_r   <= 64'd0;
            ready_r    <= DivResultNotReady;
        end else begin
            state_r    <= state_s;
            dividend_r <= dividend_s;
            divisor_r  <= divisor_s;
            cnt_r      <= cnt_s;
            sign1_r    <= sign1_s;
            sign2_r    <= sign2_s;
            result_r   <= result_s;
            ready_r    <= ready_s;
        end
    end

    // Next-state, iteration step and sign fix.
    always_comb begin
        state_s    = state_r;
        dividend_s = dividend_r;
        divisor_s  = divisor_r;
        cnt_s      = cnt_r;
        sign1_s    = sign1_r;
        sign2_s    = sign2_r;
        result_s   = result_r;
        ready_s    = ready_r;

        diff_s = {1'b0, dividend_r[63:32]} - {1'b0, divisor_r};

        // Sign flags already include the signed/unsigned selection.
        quot_fix_s = (sign1_r ^ sign2_r) ? negate(dividend_r[31:0]) : dividend_r[31:0];
        rem_fix_s  = sign1_r ? negate(dividend_r[64:33]) : dividend_r[64:33];

        case (state_r)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == ZeroWord) begin
                        state_s = DivByZero;
                    end else begin
                        state_s    = DivOn;
                        cnt_s      = 6'd0;
                        dividend_s = {ZeroWord, magnitude(signed_div_i, opdata1_i), 1'b0};
                        divisor_s  = magnitude(signed_div_i, opdata2_i);
                        sign1_s    = signed_div_i & opdata1_i[RegBus-1];
                        sign2_s    = signed_div_i & opdata2_i[RegBus-1];
                    end
                end else begin
                    ready_s  = DivResultNotReady;
                    result_s = 64'd0;
                end
            end
            DivByZero: begin
                dividend_s = 65'd0;
                result_s   = 64'd0;
                ready_s    = DivResultReady;
                state_s    = DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    state_s  = DivFree;
                    ready_s  = DivResultNotReady;
                    result_s = 64'd0;
                end else if (cnt_r != 6'd32) begin
                    if (diff_s[32]) begin
                        dividend_s = {dividend_r[63:0], 1'b0};
                    end else begin
                        dividend_s = {diff_s[31:0], dividend_r[31:0], 1'b1};
                    end
                    cnt_s = cnt_r + 6'd1;
                end else begin
                    result_s = {rem_fix_s, quot_fix_s};
                    ready_s  = DivResultReady;
                    state_s  = DivEnd;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_s  = DivFree;
                    ready_s  = DivResultNotReady;
                    result_s = 64'd0;
                end else begin
                    ready_s  = DivResultReady;
                end
            end
            default: begin
                state_s  = DivFree;
                ready_s  = DivResultNotReady;
                result_s = 64'd0;
            end
        endcase
    end

    assign result_o = result_r;
    assign ready_o  = ready_r;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus random operands
// checked against an arithmetic reference model.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    ex_div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic, truncating division, remainder follows dividend.
    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Request a division and wait for ready; checks latency and result, leaves start_i high.
    task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b, input string tag);
        int cycles;
        int exp_lat;
        logic [63:0] exp_res;
        exp_res = model(sg, a, b);
        exp_lat = (b == 32'd0) ? 1 : 33;
        @(negedge clk);
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        @(posedge clk);
        cycles = 100;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (ready_o === 1'b1) begin
                cycles = n;
                break;
            end
        end
        check({tag, "_lat"}, 64'(cycles), 64'(exp_lat));
        check({tag, "_res"}, result_o, exp_res);
    endtask

    // Drop start_i and confirm the outputs clear on the next edge.
    task automatic finish_div(input string tag);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_rdy_clr"}, {63'd0, ready_o}, 64'd0);
        check({tag, "_res_clr"}, result_o, 64'd0);
    endtask

    initial begin
        int ready_seen;
        logic [63:0] held;
        logic        sg;
        logic [31:0] a, b;
        int          sel;

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdy", {63'd0, ready_o}, 64'd0);
        check("reset_res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        launch(1'b0, 32'd100, 32'd7, "u100_7");
        check("u100_7_const", result_o, 64'h00000002_0000000E);
        finish_div("u100_7");

        launch(1'b1, 32'hFFFFFFF9, 32'h00000002, "sm7_2");
        check("sm7_2_const", result_o, 64'hFFFFFFFF_FFFFFFFD);
        finish_div("sm7_2");

        launch(1'b1, 32'h80000000, 32'hFFFFFFFF, "sovf");
        check("sovf_const", result_o, 64'h00000000_80000000);
        finish_div("sovf");

        launch(1'b0, 32'd5, 32'd0, "div0");
        finish_div("div0");

        // Annul after E10; ready must never rise.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        ready_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0) ready_seen++;
        end
        check("annul_no_ready", 64'(ready_seen), 64'd0);
        launch(1'b0, 32'd9, 32'd3, "after_annul");
        check("after_annul_const", result_o, 64'h00000000_00000003);
        finish_div("after_annul");

        // Start together with annul in FREE is refused.
        @(negedge clk);
        start_i   = 1'b1;
        annul_i   = 1'b1;
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        ready_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0) ready_seen++;
        end
        check("start_annul_refused", 64'(ready_seen), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;

        // Asynchronous reset mid-division (after E20), between edges.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_rdy", {63'd0, ready_o}, 64'd0);
        check("rst_mid_res", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b1;
        launch(1'b0, 32'hFFFFFFFF, 32'd1, "after_rst");
        check("after_rst_const", result_o, 64'h00000000_FFFFFFFF);
        finish_div("after_rst");

        // Asynchronous reset while a nonzero result is held.
        launch(1'b0, 32'd100, 32'd7, "pre_rst_end");
        #2 rst = 1'b0;
        #1;
        check("rst_end_rdy", {63'd0, ready_o}, 64'd0);
        check("rst_end_res", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b1;

        // Hold start_i in END for 5 cycles.
        launch(1'b1, 32'hFFFFFC18, 32'd37, "hold");
        held = model(1'b1, 32'hFFFFFC18, 32'd37);
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            check("hold_rdy", {63'd0, ready_o}, 64'd1);
            check("hold_res", result_o, held);
        end
        finish_div("hold");

        // Random operands, with extra weight on zero, all-ones and small divisors.
        for (int k = 0; k < 24; k++) begin
            sg  = 1'($urandom_range(0, 1));
            a   = $urandom;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 15));
                3:       b = a;
                default: b = $urandom;
            endcase
            if (sel == 4) a = 32'h80000000;
            launch(sg, a, b, "rand");
            finish_div("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle radix-2 restoring divider used by the execute stage for DIV/DIVU. The EX stage receives operands from the ID/EX pipeline register and starts the divider. It holds the pipeline stalled until `ready_o` rises, then writes the 64-bit result to HI/LO. Only one division is in flight at a time. The EX stage can annul an in-flight division when the instruction is flushed.

## Interface
Parameters:
- none. Operand width is fixed at 32 (`RegBus`); result width is 64 (`DoubleRegBus`).

Ports:
- Clock and reset: one clock, `clk`. Reset is `rst`, asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU
- `opdata1_i`  in  32  dividend; sampled only on the start edge
- `opdata2_i`  in  32  divisor; sampled only on the start edge
- `start_i`  in  1  request. Must stay high until `ready_o` has been seen.
- `annul_i`  in  1  cancel the current or requested division
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}; registered
- `ready_o`  out  1  result valid; registered

## Operation
States: FREE, BYZERO, ON, END.

Internal registers:
- `dividend`: 65 bits
- `divisor`: 32 bits, holding the absolute value
- `cnt`: 6 bits
- sign flags of both operands, latched on the start edge

FREE:
- On `start_i=1` and `annul_i=0`:
  - If `opdata2_i==0`, go to BYZERO.
  - Otherwise, `cnt<=0` and `dividend<={32'b0, |op1|, 1'b0}`. Take `|opN|` only when `signed_div_i=1`; otherwise use the raw value. Go to ON.
- Otherwise, stay in FREE with `ready_o=0` and `result_o=0`.

BYZERO:
- `dividend<=0`, then go to END on the next edge.

ON:
- If `annul_i=1`, go to FREE immediately. `ready_o` stays 0 and `result_o` stays 0.
- Otherwise, while `cnt<32`, do one iteration per edge:
  - `diff = {1'b0, dividend[63:32]} - {1'b0, divisor}` (33-bit).
  - If `diff[32]` (negative): `dividend <= {dividend[63:0], 1'b0}`.
  - Else: `dividend <= {diff[31:0], dividend[31:0], 1'b1}`.
  - `cnt <= cnt + 1`.
- When `cnt==32`, apply the sign fix and go to END:
  - Negate the quotient if `signed_div_i` and `sign1 ^ sign2`.
  - Negate the remainder if `signed_div_i` and `sign1`.
  - `result_o <= {dividend[64:33], dividend[31:0]}` after the fix. `ready_o <= 1`.

END:
- Hold `result_o` and `ready_o=1` while `start_i=1`.
- On `start_i=0`, go to FREE with `ready_o<=0` and `result_o<=0`.

Arithmetic rules:
- Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wraps, no trap).
- Division by zero gives `result_o=0`. The architectural result is undefined; the block still completes.

Reset:
- On `rst=0` at any time, including mid-division: state=FREE, `cnt=0`, `dividend=0`, `result_o=64'h0`, `ready_o=0`.

## Timing
- Edge E0 samples `start_i` in FREE. E1–E32 perform the 32 iterations. E33 applies the sign fix, and `ready_o=1` is visible after E33.
- Latency is 34 edges including E0.
- Divide by zero: start at E0 (enter BYZERO), END at E1, `ready_o=1` after E1.
- `start_i` dropping while in ON: ignored. Only `annul_i` cancels an in-flight division.
- A new division is accepted no earlier than one edge after `ready_o` falls, i.e. after one FREE cycle.
- Simultaneous `start_i` and `annul_i` in FREE: the request is not accepted.

## Structure
Shared package / `defines.v` holds:
- State encodings: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
- `DivResultReady` / `DivResultNotReady`, `DivStart` / `DivStop`.
- `DoubleRegBus`, `ZeroWord`.

No sub-module: the iteration step and the sign fix are small and stay inline in the single always block.

## Test plan
- Unsigned 100 / 7 (`signed_div_i=0`) → after 34 edges `ready_o=1`, `result_o=64'h00000002_0000000E`.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) → `result_o=64'hFFFFFFFF_FFFFFFFD`. Also signed 0x80000000 / 0xFFFFFFFF → `64'h00000000_80000000`.
- Divide by zero: 5 / 0 → `ready_o=1` after E1, `result_o=0`. Then drop `start_i` → `ready_o=0` on the next edge.
- Annul: assert `annul_i` after E10 → state FREE, `ready_o` never rises. A following 9 / 3 completes with `64'h00000000_00000003`.
- Reset: assert `rst` low mid-division (after E20), between clock edges → `ready_o=0` and `result_o=0` immediately (asynchronous). After release, 0xFFFFFFFF / 1 unsigned gives `64'h00000000_FFFFFFFF`.
- Hold `start_i` high for 5 cycles in END → `result_o` is stable and `ready_o=1` throughout.
